// File: rtl/pw_pkg.sv
// Shared definitions for the password-entry controller and its attempt counter.
//   pw_state_e : controller states
//   KEY_CLEAR  : keypad code that clears a partial entry or relocks after a grant
//   DIGIT_MAX  : largest keypad code treated as a decimal digit
//   ATT_W      : width of the downstream failed-attempt counter
package pw_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StDeny,
    StEval,
    StGrant,
    StLocked
  } pw_state_e;

  localparam logic [3:0]  KEY_CLEAR = 4'hA;
  localparam int unsigned DIGIT_MAX = 9;
  localparam int unsigned ATT_W     = 6;

endpackage

// File: rtl/pw_entry_fsm_if.sv
// Keypad / attempt-counter / status bundle of the password-entry controller.
//   key_valid, key_code : keypad strobe and code
//   pw_ref              : reference password, first digit in the most significant nibble
//   att_count           : value read back from the failed-attempt counter
//   att_en, att_clr_n   : increment enable and active-low clear to that counter
//   unlock, fail, locked, digits_entered : status outputs
// The slave modport is the controller; master is the surrounding system.
interface pw_entry_fsm_if
  import pw_pkg::*;
#(
  parameter int unsigned PW_LEN  = 4,
  parameter int unsigned DIGIT_W = 4
) ();

  logic                        key_valid;
  logic [DIGIT_W-1:0]          key_code;
  logic [PW_LEN*DIGIT_W-1:0]   pw_ref;
  logic [ATT_W-1:0]            att_count;
  logic                        att_en;
  logic                        att_clr_n;
  logic                        unlock;
  logic                        fail;
  logic                        locked;
  logic [2:0]                  digits_entered;

  modport master (
    output key_valid, key_code, pw_ref, att_count,
    input  att_en, att_clr_n, unlock, fail, locked, digits_entered
  );

  modport slave (
    input  key_valid, key_code, pw_ref, att_count,
    output att_en, att_clr_n, unlock, fail, locked, digits_entered
  );

endinterface

// File: rtl/pw_lock_timer.sv
// Loadable down-counter used to time the lockout period.
//   clock      : system clock, rising edge
//   reset      : synchronous, active-low reset (count cleared)
//   load_i     : load load_val_i this cycle (takes priority over decrement)
//   load_val_i : value to load
//   dec_i      : decrement by one; holds at zero
//   done_o     : count is zero
module pw_lock_timer #(
  parameter int unsigned Width = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/pw_entry_fsm.sv
// Keypad password-entry controller.
// Collects PW_LEN digits, compares them against pw_ref, then either grants access
// (unlock level, one-cycle counter clear) or reports a failure (fail/att_en pulse).
// After a failure the updated attempt count is read back; reaching MAX_FAILS starts a
// lockout of exactly LOCK_CYCLES cycles, followed by a one-cycle counter clear.
//   clock  : system clock, rising edge
//   reset  : synchronous, active-low reset
//   bus_io : keypad, attempt-counter and status signals (slave side)
// All outputs are registered.
module pw_entry_fsm
  import pw_pkg::*;
#(
  parameter int unsigned PW_LEN      = 4,
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  pw_entry_fsm_if.slave        bus_io
);

  localparam int unsigned BufW   = PW_LEN * DIGIT_W;
  localparam int unsigned TimerW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  pw_state_e       state_q;
  logic [BufW-1:0] buf_q;
  logic [2:0]      cnt_q;
  logic            unlock_q;
  logic            fail_q;
  logic            att_en_q;
  logic            att_clr_n_q;
  logic            locked_q;

  logic [BufW-1:0] buf_shift;
  logic            is_digit;
  logic            is_clear;
  logic            over_limit;
  logic            timer_load;
  logic            timer_dec;
  logic            timer_done;

  always_comb begin
    buf_shift  = (buf_q << DIGIT_W) | BufW'(bus_io.key_code);
    is_digit   = (32'(bus_io.key_code) <= DIGIT_MAX);
    is_clear   = (bus_io.key_code == DIGIT_W'(KEY_CLEAR));
    // att_count already includes the increment issued during the failure cycle
    over_limit = (32'(bus_io.att_count) >= MAX_FAILS);
    timer_load = (state_q == StEval) && over_limit;
    timer_dec  = (state_q == StLocked);
  end

  pw_lock_timer #(
    .Width (TimerW)
  ) u_lock_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (TimerW'(LOCK_CYCLES - 1)),
    .dec_i      (timer_dec),
    .done_o     (timer_done)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      cnt_q       <= '0;
      unlock_q    <= 1'b0;
      fail_q      <= 1'b0;
      att_en_q    <= 1'b0;
      locked_q    <= 1'b0;
      att_clr_n_q <= 1'b0;  // keep the attempt counter cleared during reset
    end else begin
      fail_q      <= 1'b0;
      att_en_q    <= 1'b0;
      att_clr_n_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (bus_io.key_valid) begin
            if (is_digit) begin
              buf_q <= buf_shift;
              // 3-bit count: with PW_LEN == 8 it reads 0 while checking, which is harmless
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'(PW_LEN - 1)) begin
                state_q <= StCheck;
              end
            end else if (is_clear) begin
              buf_q <= '0;
              cnt_q <= '0;
            end
          end
        end
        StCheck: begin
          buf_q <= '0;
          cnt_q <= '0;
          if (buf_q == bus_io.pw_ref) begin
            state_q     <= StGrant;
            unlock_q    <= 1'b1;
            att_clr_n_q <= 1'b0;
          end else begin
            state_q  <= StDeny;
            fail_q   <= 1'b1;
            att_en_q <= 1'b1;
          end
        end
        StDeny: begin
          state_q <= StEval;
        end
        StEval: begin
          if (over_limit) begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          if (bus_io.key_valid && is_clear) begin
            state_q  <= StIdle;
            unlock_q <= 1'b0;
          end
        end
        StLocked: begin
          if (timer_done) begin
            state_q     <= StIdle;
            locked_q    <= 1'b0;
            att_clr_n_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.att_en         = att_en_q;
  assign bus_io.att_clr_n      = att_clr_n_q;
  assign bus_io.unlock         = unlock_q;
  assign bus_io.fail           = fail_q;
  assign bus_io.locked         = locked_q;
  assign bus_io.digits_entered = cnt_q;

endmodule

// File: tb/tb_pw_entry_fsm.sv
// Bench for pw_entry_fsm: PW_LEN=4, pw_ref=16'h1234, MAX_FAILS=3, LOCK_CYCLES=8, with a
// 6-bit attempt counter modelled alongside. A timeline model predicts every output each
// cycle; directed scenarios add literal checkpoints, then random keys and resets follow.
module tb_pw_entry_fsm;
  import pw_pkg::*;

  localparam int unsigned PwLen      = 4;
  localparam int unsigned DigitW     = 4;
  localparam int unsigned MaxFails   = 3;
  localparam int unsigned LockCycles = 8;
  localparam logic [15:0] PwRef      = 16'h1234;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pw_entry_fsm_if #(.PW_LEN(PwLen), .DIGIT_W(DigitW)) bus ();

  pw_entry_fsm #(
    .PW_LEN      (PwLen),
    .DIGIT_W     (DigitW),
    .MAX_FAILS   (MaxFails),
    .LOCK_CYCLES (LockCycles)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus)
  );

  // Downstream failed-attempt counter
  logic [ATT_W-1:0] att_cnt_q = '0;
  always @(posedge clock) begin
    if (bus.att_clr_n === 1'b0) att_cnt_q <= '0;
    else if (bus.att_en === 1'b1) att_cnt_q <= att_cnt_q + 1'b1;
  end
  assign bus.att_count = att_cnt_q;

  typedef struct {
    bit unlock;
    bit fail;
    bit att_en;
    bit clr_n;
    bit locked;
    bit eval;     // decision on the attempt count follows this cycle
    int de;
  } frame_t;

  int     total = 0;
  int     bad   = 0;
  bit     chk_en = 1'b0;

  frame_t cur, prv, m_f;
  frame_t sched[$];
  int     digs[$];
  bit     granted, pend_eval, m_busy, kv;
  int     kc, m_cnt, m_val;
  int     pw_digits[4] = '{1, 2, 3, 4};

  function automatic frame_t idle_frame(int de);
    frame_t f;
    f.unlock = 1'b0; f.fail = 1'b0; f.att_en = 1'b0; f.clr_n = 1'b1;
    f.locked = 1'b0; f.eval = 1'b0; f.de = de;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    cur = idle_frame(0);
    cur.clr_n = 1'b0;
    m_cnt = 0;
    granted = 1'b0;
    pend_eval = 1'b0;
  end

  // Reference model: predicts outputs after each edge, then compares #1 later
  always begin
    @(posedge clock);
    kv  = (bus.key_valid === 1'b1);
    kc  = int'(bus.key_code);
    prv = cur;
    if (!prv.clr_n) m_cnt = 0;
    else if (prv.att_en) m_cnt++;
    if (reset == 1'b0) begin
      cur = idle_frame(0);
      cur.clr_n = 1'b0;
      sched.delete();
      digs.delete();
      granted   = 1'b0;
      pend_eval = 1'b0;
    end else begin
      m_busy = 1'b0;
      if (pend_eval) begin
        pend_eval = 1'b0;
        m_busy    = 1'b1;
        if (m_cnt >= int'(MaxFails)) begin
          for (int i = 0; i < int'(LockCycles); i++) begin
            m_f = idle_frame(0);
            m_f.locked = 1'b1;
            sched.push_back(m_f);
          end
          m_f = idle_frame(0);
          m_f.clr_n = 1'b0;
          sched.push_back(m_f);
        end
      end
      if (sched.size() > 0) begin
        cur = sched.pop_front();
        if (cur.eval) pend_eval = 1'b1;
      end else if (m_busy) begin
        cur = idle_frame(0);
      end else if (granted) begin
        cur = idle_frame(0);
        if (kv && kc == 10) granted = 1'b0;
        else cur.unlock = 1'b1;
      end else if (kv && kc <= 9) begin
        digs.push_back(kc);
        if (digs.size() == PwLen) begin
          m_val = 0;
          foreach (digs[i]) m_val = m_val * (1 << DigitW) + digs[i];
          cur = idle_frame(int'(PwLen % 8));
          m_f = idle_frame(0);
          if (m_val == int'(PwRef)) begin
            m_f.unlock = 1'b1;
            m_f.clr_n  = 1'b0;
            sched.push_back(m_f);
            granted = 1'b1;
          end else begin
            m_f.fail   = 1'b1;
            m_f.att_en = 1'b1;
            sched.push_back(m_f);
            m_f = idle_frame(0);
            m_f.eval = 1'b1;
            sched.push_back(m_f);
          end
          digs.delete();
        end else begin
          cur = idle_frame(digs.size());
        end
      end else if (kv && kc == 10) begin
        digs.delete();
        cur = idle_frame(0);
      end else begin
        cur = idle_frame(digs.size());
      end
    end
    #1;
    if (chk_en) begin
      chk("m_unlock", bus.unlock, cur.unlock);
      chk("m_fail", bus.fail, cur.fail);
      chk("m_att_en", bus.att_en, cur.att_en);
      chk("m_att_clr_n", bus.att_clr_n, cur.clr_n);
      chk("m_locked", bus.locked, cur.locked);
      chk("m_digits", bus.digits_entered, cur.de);
      chk("m_att_count", bus.att_count, m_cnt);
    end
  end

  task automatic press(input logic [3:0] code);
    @(negedge clock);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clock);
    bus.key_valid = 1'b0;
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d);
  endtask

  int  nlock;
  bit  was_locked;
  int  r, ridx;

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.pw_ref    = PwRef;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_clr_n", bus.att_clr_n, 0);
    chk("rst_digits", bus.digits_entered, 0);
    chk("rst_unlock", bus.unlock, 0);
    chk("rst_locked", bus.locked, 0);
    chk_en = 1'b1;
    reset = 1'b1;

    // Correct entry
    enter(4'd1, 4'd2, 4'd3, 4'd4);
    chk("ok_check_digits", bus.digits_entered, 4);
    chk("ok_check_unlock", bus.unlock, 0);
    @(negedge clock);
    chk("ok_unlock", bus.unlock, 1);
    chk("ok_clr_pulse", bus.att_clr_n, 0);
    @(negedge clock);
    chk("ok_clr_release", bus.att_clr_n, 1);
    chk("ok_count", bus.att_count, 0);
    press(4'hA);
    chk("relock_unlock", bus.unlock, 0);

    // Single wrong entry
    enter(4'd1, 4'd2, 4'd3, 4'd5);
    @(negedge clock);
    chk("wrong_fail", bus.fail, 1);
    @(negedge clock);
    chk("wrong_fail_drop", bus.fail, 0);
    chk("wrong_count", bus.att_count, 1);
    @(negedge clock);
    chk("wrong_locked", bus.locked, 0);
    chk("wrong_unlock", bus.unlock, 0);

    // Two more failures reach the lockout threshold
    enter(4'd9, 4'd9, 4'd9, 4'd9);
    repeat (3) @(negedge clock);
    enter(4'd4, 4'd3, 4'd2, 4'd1);
    nlock = 0;
    was_locked = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bus.locked === 1'b1) begin
        if (nlock == 0) chk("lock_count3", bus.att_count, 3);
        nlock++;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'((i % 4) + 1);
      end else begin
        if (was_locked) chk("post_lock_clr", bus.att_clr_n, 0);
        bus.key_valid = 1'b0;
      end
      was_locked = (bus.locked === 1'b1);
    end
    chk("lock_len", nlock, 8);
    chk("post_lock_count", bus.att_count, 0);
    chk("post_lock_unlock", bus.unlock, 0);

    // Clear and ignored codes
    press(4'd1); press(4'd2);
    chk("ign_digits2", bus.digits_entered, 2);
    press(4'hC);
    chk("ign_c", bus.digits_entered, 2);
    press(4'hF);
    chk("ign_f", bus.digits_entered, 2);
    press(4'hA);
    chk("clr_digits", bus.digits_entered, 0);
    enter(4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clock);
    chk("clr_unlock", bus.unlock, 1);
    press(4'hA);
    chk("relock2", bus.unlock, 0);
    enter(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (2) @(negedge clock);
    chk("relock_again", bus.unlock, 1);
    press(4'hA);

    // Reset mid-entry
    press(4'd1); press(4'd2);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_digits", bus.digits_entered, 0);
    chk("rst_mid_clr", bus.att_clr_n, 0);
    reset = 1'b1;

    // Reset during lockout
    enter(4'd5, 4'd5, 4'd5, 4'd5); repeat (3) @(negedge clock);
    enter(4'd5, 4'd5, 4'd5, 4'd5); repeat (3) @(negedge clock);
    enter(4'd5, 4'd5, 4'd5, 4'd5); repeat (3) @(negedge clock);
    chk("rl_locked", bus.locked, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rl_unlocked", bus.locked, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("rl_count", bus.att_count, 0);

    // Random keys with occasional reset pulses
    ridx = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 299) != 0);
      bus.key_valid = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        bus.key_code = 4'(pw_digits[ridx]);
        ridx = (ridx + 1) % 4;
      end else if (r < 7) begin
        bus.key_code = 4'($urandom_range(0, 9));
      end else if (r == 7) begin
        bus.key_code = 4'hA;
      end else begin
        bus.key_code = 4'($urandom_range(11, 15));
      end
    end
    @(negedge clock);
    reset = 1'b1;
    bus.key_valid = 1'b0;
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
